// File: rtl/sgd_pkg.sv
// Shared Q8.8 constants, FSM state encoding and saturation helper for the SGD trainer.
package sgd_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned WORD_W    = 16;

    typedef enum logic [2:0] {LOAD, PREDICT, ERR, UPDATE, NEXT, DONE} sgd_state_e;

    // Clamp a wide signed value into the signed 16-bit Q8.8 range.
    function automatic logic signed [WORD_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sh0000_7fff) return 16'sh7fff;
        if (v < 32'shffff_8000) return 16'sh8000;
        return 16'(v);
    endfunction

endpackage

// File: rtl/sgd_serial_loader.sv
// Bit-serial record loader: assembles words N..0 (LSB first) into a record and stores it.
module sgd_serial_loader
    import sgd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned MEM_AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  s,
    input  logic [3:0]            n,
    input  logic [ADDR_WIDTH-1:0] last_rec,
    input  logic [MEM_AW-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done
);

    logic [3:0]            bit_q;
    logic [3:0]            word_q;
    logic [3:0]            word_idx;
    logic [ADDR_WIDTH-1:0] rec_q;
    logic [DATA_WIDTH-1:0] rec_buf_q;
    logic [DATA_WIDTH-1:0] rec_buf_d;
    logic                  rec_end;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Place the incoming bit at 16*word+bit; words arrive highest index first.
    always_comb begin
        word_idx  = n - word_q;
        rec_end   = en && (bit_q == 4'(WORD_W - 1)) && (word_q == n);
        done      = rec_end && (rec_q == last_rec);
        rec_buf_d = rec_buf_q;
        rec_buf_d[{word_idx, bit_q}] = s;
        rd_data   = mem[rd_addr];
    end

    // Bit, word and record counters plus the record assembly buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_q     <= '0;
            word_q    <= '0;
            rec_q     <= '0;
            rec_buf_q <= '0;
        end else if (en) begin
            rec_buf_q <= rec_buf_d;
            bit_q     <= bit_q + 4'd1;
            if (bit_q == 4'(WORD_W - 1)) begin
                if (word_q == n) begin
                    word_q <= '0;
                    rec_q  <= rec_q + 1'b1;
                end else begin
                    word_q <= word_q + 4'd1;
                end
            end
        end
    end

    // Commit the completed record, including its final bit.
    always_ff @(posedge clk) begin
        if (rst && rec_end) mem[rec_q[MEM_AW-1:0]] <= rec_buf_d;
    end

endmodule

// File: rtl/main.sv
// Streaming SGD linear-regression trainer top level.
// Optional SGD_SAT_EN: saturating arithmetic everywhere; otherwise two's-complement wrap.
module main
    import sgd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MAX_FEATURES = 15,
    parameter int unsigned DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
    parameter int unsigned DEPTH        = 100,
    parameter int unsigned LENGTH       = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S,
    input  logic [3:0]            feat,
    input  logic [7:0]            epoch,
    input  logic [3:0]            learn_rate,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic [3:0]            w_sel,
    output logic [LENGTH-1:0]     w_out,
    output logic                  SGD_DONE
);

    localparam int unsigned MemAw = $clog2(DEPTH);

    function automatic logic signed [15:0] fit16(input logic signed [31:0] v);
`ifdef SGD_SAT_EN
        return sat16(v);
`else
        return 16'(v);
`endif
    endfunction

    sgd_state_e               state_q;
    logic                     cfg_valid_q;
    logic [3:0]               n_q, lr_q, k_q;
    logic [7:0]               ep_lim_q, ep_q;
    logic [ADDR_WIDTH-1:0]    dp_q, rec_idx_q;
    logic signed [23:0]       acc_q;
    logic signed [15:0]       err_q;
    logic                     done_q;
    logic signed [LENGTH-1:0] w_q [MAX_FEATURES+1];

    logic [3:0]               n_in, n_eff;
    logic [ADDR_WIDTH-1:0]    dp_in, dp_eff;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     load_done;
    logic signed [15:0]       xk, yv, wk, pred, err_d, delta, w_new, acc_sat;
    logic signed [31:0]       prod, sum, upd, dlt32;
    logic signed [23:0]       acc_d;

    // Config is live until captured, so the very first serial bit uses the input values.
    always_comb begin
        n_in   = (32'(feat) > MAX_FEATURES) ? 4'(MAX_FEATURES) : feat;
        dp_in  = (32'(data_points) >= DEPTH) ? ADDR_WIDTH'(DEPTH - 1) : data_points;
        n_eff  = cfg_valid_q ? n_q : n_in;
        dp_eff = cfg_valid_q ? dp_q : dp_in;
    end

    sgd_serial_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MEM_AW     (MemAw)
    ) u_loader (
        .clk      (CLK),
        .rst      (RST),
        .en       (state_q == LOAD),
        .s        (S),
        .n        (n_eff),
        .last_rec (dp_eff),
        .rd_addr  (rec_idx_q[MemAw-1:0]),
        .rd_data  (rd_data),
        .done     (load_done)
    );

    // MAC, error and weight-update datapath for the current record word k.
    always_comb begin
        xk    = rd_data[{k_q, 4'h0} +: 16];
        yv    = rd_data[15:0];
        wk    = w_q[k_q];
        prod  = 32'(wk) * 32'(xk);
        sum   = 32'(acc_q) + (prod >>> FRAC_BITS);
        acc_sat = sat16(sum);
`ifdef SGD_SAT_EN
        acc_d = 24'(acc_sat);
`else
        acc_d = 24'(sum);
`endif
        pred  = fit16(32'(acc_q));
        err_d = fit16(32'(pred) - 32'(yv));
        upd   = 32'(err_q) * 32'(xk);
        if (k_q == 4'd0) dlt32 = 32'(err_q) >>> lr_q;
        else             dlt32 = (upd >>> FRAC_BITS) >>> lr_q;
        delta = fit16(dlt32);
        w_new = fit16(32'(wk) - 32'(delta));
    end

    // Training sequencer: config capture, state transitions and all registered state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= LOAD;
            cfg_valid_q <= 1'b0;
            n_q         <= '0;
            lr_q        <= '0;
            ep_lim_q    <= '0;
            dp_q        <= '0;
            k_q         <= '0;
            ep_q        <= '0;
            rec_idx_q   <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_FEATURES) + 1; i++) w_q[i] <= '0;
        end else begin
            if (!cfg_valid_q) begin
                cfg_valid_q <= 1'b1;
                n_q         <= n_in;
                dp_q        <= dp_in;
                lr_q        <= learn_rate;
                ep_lim_q    <= epoch;
            end
            unique case (state_q)
                LOAD: begin
                    if (load_done) begin
                        k_q       <= '0;
                        rec_idx_q <= '0;
                        if (ep_lim_q == 8'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PREDICT;
                        end
                    end
                end
                PREDICT: begin
                    acc_q <= (k_q == 4'd0) ? 24'(w_q[0]) : acc_d;
                    if (k_q == n_q) state_q <= ERR;
                    else            k_q     <= k_q + 4'd1;
                end
                ERR: begin
                    err_q   <= err_d;
                    k_q     <= '0;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    w_q[k_q] <= w_new;
                    if (k_q == n_q) state_q <= NEXT;
                    else            k_q     <= k_q + 4'd1;
                end
                NEXT: begin
                    k_q     <= '0;
                    state_q <= PREDICT;
                    if (rec_idx_q == dp_q) begin
                        rec_idx_q <= '0;
                        ep_q      <= ep_q + 8'd1;
                        if (ep_q + 8'd1 == ep_lim_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        rec_idx_q <= rec_idx_q + 1'b1;
                    end
                end
                DONE: ;
                default: state_q <= LOAD;
            endcase
        end
    end

    assign w_out    = w_q[w_sel];
    assign SGD_DONE = done_q;

endmodule

// File: tb/tb_main.sv
// Directed self-checking bench for the SGD trainer top level.
module tb_main;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        S = 1'b0;
    logic [3:0]  feat = '0;
    logic [7:0]  epoch = '0;
    logic [3:0]  learn_rate = '0;
    logic [11:0] data_points = '0;
    logic [3:0]  w_sel = '0;
    logic [15:0] w_out;
    logic        SGD_DONE;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] recw [16];

    main dut (
        .CLK         (CLK),
        .RST         (RST),
        .S           (S),
        .feat        (feat),
        .epoch       (epoch),
        .learn_rate  (learn_rate),
        .data_points (data_points),
        .w_sel       (w_sel),
        .w_out       (w_out),
        .SGD_DONE    (SGD_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] n, input logic [11:0] dp, input logic [7:0] ep,
                         input logic [3:0] lr);
        RST = 1'b0;
        S = 1'b0;
        feat = n;
        data_points = dp;
        epoch = ep;
        learn_rate = lr;
        repeat (5) tick();
        RST = 1'b1;
    endtask

    task automatic clear_rec();
        for (int i = 0; i < 16; i++) recw[i] = 16'h0000;
    endtask

    task automatic send_rec(input int n);
        for (int j = n; j >= 0; j--) begin
            for (int b = 0; b < 16; b++) begin
                S = recw[j][b];
                tick();
            end
        end
        S = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int used);
        used = 0;
        while (SGD_DONE !== 1'b1 && used < budget) begin
            tick();
            used++;
        end
    endtask

    task automatic read_w(input logic [3:0] sel, output logic [15:0] v);
        w_sel = sel;
        #1;
        v = w_out;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        start(4'd3, 12'd0, 8'd1, 4'd1);
        n_cmp++;
        if (SGD_DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b want 0", SGD_DONE);
        end
        for (int i = 0; i < 16; i++) begin
            read_w(4'(i), v);
            n_cmp++;
            if (v !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_w%0d: got %h want 0000", i, v);
            end
        end
    endtask

    task automatic test_bias(input logic [7:0] ep, input logic [15:0] exp_b);
        logic [15:0] v;
        int used;
        start(4'd0, 12'd0, ep, 4'd1);
        clear_rec();
        recw[0] = 16'h0100;
        send_rec(0);
        wait_done(200, used);
        n_cmp++;
        if (SGD_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL bias_ep%0d_done: got %b want 1 after %0d cycles", ep, SGD_DONE, used);
        end
        read_w(4'd0, v);
        n_cmp++;
        if (v !== exp_b) begin
            n_bad++;
            $display("FAIL bias_ep%0d_b: got %h want %h", ep, v, exp_b);
        end
        read_w(4'd1, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            n_bad++;
            $display("FAIL bias_ep%0d_w1_unused: got %h want 0000", ep, v);
        end
    endtask

    task automatic test_one_feature();
        logic [15:0] v;
        int used;
        start(4'd1, 12'd0, 8'd1, 4'd1);
        clear_rec();
        recw[0] = 16'h0200;
        recw[1] = 16'h0100;
        send_rec(1);
        wait_done(200, used);
        n_cmp++;
        if (SGD_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL feat1_done: got %b want 1 after %0d cycles", SGD_DONE, used);
        end
        read_w(4'd1, v);
        n_cmp++;
        if (v !== 16'h0100) begin
            n_bad++;
            $display("FAIL feat1_w1: got %h want 0100", v);
        end
        read_w(4'd0, v);
        n_cmp++;
        if (v !== 16'h0100) begin
            n_bad++;
            $display("FAIL feat1_b: got %h want 0100", v);
        end
        read_w(4'd2, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            n_bad++;
            $display("FAIL feat1_w2: got %h want 0000", v);
        end
    endtask

    task automatic test_epoch_zero();
        logic [15:0] v;
        int used;
        start(4'd1, 12'd1, 8'd0, 4'd1);
        clear_rec();
        recw[0] = 16'h0300;
        recw[1] = 16'h0100;
        send_rec(1);
        recw[0] = 16'hff00;
        recw[1] = 16'h0080;
        send_rec(1);
        wait_done(2, used);
        n_cmp++;
        if (SGD_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL ep0_done: got %b want 1 within 2 cycles", SGD_DONE);
        end
        for (int i = 0; i < 3; i++) begin
            read_w(4'(i), v);
            n_cmp++;
            if (v !== 16'h0000) begin
                n_bad++;
                $display("FAIL ep0_w%0d: got %h want 0000", i, v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int used;
        start(4'd1, 12'd0, 8'd50, 4'd1);
        clear_rec();
        recw[0] = 16'h0200;
        recw[1] = 16'h0100;
        send_rec(1);
        repeat (9) tick();
        RST = 1'b0;
        tick();
        n_cmp++;
        if (SGD_DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_done: got %b want 0", SGD_DONE);
        end
        read_w(4'd0, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_b: got %h want 0000", v);
        end
        start(4'd0, 12'd0, 8'd1, 4'd1);
        clear_rec();
        recw[0] = 16'h0100;
        send_rec(0);
        wait_done(200, used);
        n_cmp++;
        if (SGD_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_done: got %b want 1 after %0d cycles", SGD_DONE, used);
        end
        read_w(4'd0, v);
        n_cmp++;
        if (v !== 16'h0080) begin
            n_bad++;
            $display("FAIL reload_b: got %h want 0080", v);
        end
        read_w(4'd1, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            n_bad++;
            $display("FAIL reload_w1: got %h want 0000", v);
        end
    endtask

    task automatic test_convergence();
        logic [15:0] v;
        int used;
        int d;
        int want;
        logic [15:0] x1s [6];
        logic [15:0] ys [6];
        x1s = '{16'h0100, 16'hff00, 16'h0080, 16'hff80, 16'h0000, 16'h0040};
        ys  = '{16'h0180, 16'h0080, 16'h0140, 16'h00c0, 16'h0100, 16'h0120};
        start(4'd5, 12'd5, 8'd100, 4'd1);
        for (int r = 0; r < 6; r++) begin
            clear_rec();
            recw[0] = ys[r];
            recw[1] = x1s[r];
            if (r == 4) recw[2] = 16'h0020;
            if (r == 5) recw[3] = 16'hffe0;
            send_rec(5);
        end
        wait_done(20000, used);
        n_cmp++;
        if (SGD_DONE !== 1'b1) begin
            n_bad++;
            $display("FAIL conv_done: got %b want 1 after %0d cycles", SGD_DONE, used);
        end
        for (int i = 0; i < 6; i++) begin
            read_w(4'(i), v);
            want = (i == 0) ? 256 : ((i == 1) ? 128 : 0);
            d = $signed(v);
            d = d - want;
            n_cmp++;
            if (d > 16 || d < -16) begin
                n_bad++;
                $display("FAIL conv_w%0d: got %h want %h +/- 0010", i, v, 16'(want));
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        int used;
        start(4'd1, 12'd0, 8'd1, 4'd0);
        clear_rec();
        recw[0] = 16'h7fff;
        recw[1] = 16'h7fff;
        send_rec(1);
        wait_done(200, used);
        read_w(4'd1, v);
        n_cmp++;
`ifdef SGD_SAT_EN
        if (v !== 16'h7fff) begin
            n_bad++;
            $display("FAIL ovf_w1: got %h want 7fff", v);
        end
`else
        if (v !== 16'hff01) begin
            n_bad++;
            $display("FAIL ovf_w1: got %h want ff01", v);
        end
`endif
        read_w(4'd0, v);
        n_cmp++;
        if (v !== 16'h7fff) begin
            n_bad++;
            $display("FAIL ovf_b: got %h want 7fff", v);
        end
    endtask

    initial begin
        test_reset();
        test_bias(8'd1, 16'h0080);
        test_bias(8'd2, 16'h00c0);
        test_one_feature();
        test_epoch_zero();
        test_reset_mid();
        test_convergence();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
